// File: rtl/slow_clock_monitor.sv
// Brings the divided slow clock into the clk_20MHz domain as edge ticks, measures each
// half-period in fast cycles, and tracks lock/stall against the nominal half-period.
`timescale 1ns/1ps
module slow_clock_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16,
    parameter int NOMINAL_HALF = 1001,
    parameter int TOL          = 4,
    parameter int LOCK_COUNT   = 4,
    parameter int TIMEOUT      = 4095
) (
    input  logic             clk_20MHz,
    input  logic             rst,
    input  logic             slow_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             half_valid,
    output logic             locked,
    output logic             lost,
    output logic             stall
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_LO  = (NOMINAL_HALF > TOL) ? (CNT_W+1)'(NOMINAL_HALF - TOL) : '0;
    localparam logic [CNT_W:0]   TOL_HI  = (CNT_W+1)'(NOMINAL_HALF + TOL);
    localparam logic [MW-1:0]    MATCH_LOCK = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          match_q, match_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       meas_c;
    logic                   sync_last, edge_c, in_tol, timeout_c;
    logic                   valid_d, lost_d, stall_d;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign edge_c    = sync_last ^ prev_q;
    assign meas_c    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    // Compare one bit wider so the window edges never wrap.
    assign in_tol    = ({1'b0, meas_c} >= TOL_LO) && ({1'b0, meas_c} <= TOL_HI);
    assign timeout_c = (cnt_q == CNT_TO) && !edge_c;

    always_ff @(posedge clk_20MHz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        valid_d = 1'b0;
        lost_d  = 1'b0;
        stall_d = stall;
        if (edge_c) begin
            stall_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // First edge only starts the counter; its interval is not a period.
                    state_d = ACQUIRE;
                    match_d = '0;
                end
                ACQUIRE: begin
                    valid_d = 1'b1;
                    if (in_tol) begin
                        match_d = match_q + 1'b1;
                        if (match_d == MATCH_LOCK) state_d = LOCKED;
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    valid_d = 1'b1;
                    if (!in_tol) begin
                        state_d = ACQUIRE;
                        match_d = '0;
                        lost_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_c) begin
            state_d = IDLE;
            match_d = '0;
            stall_d = 1'b1;
            lost_d  = (state_q == LOCKED);
        end
    end

    always_ff @(posedge clk_20MHz or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            half_period <= '0;
            half_valid  <= 1'b0;
            locked      <= 1'b0;
            lost        <= 1'b0;
            stall       <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], slow_in};
            prev_q     <= sync_last;
            cnt_q      <= edge_c ? '0 : meas_c;
            rise_tick  <= edge_c & sync_last;
            fall_tick  <= edge_c & ~sync_last;
            half_valid <= valid_d;
            if (valid_d) half_period <= meas_c;
            locked     <= (state_d == LOCKED);
            lost       <= lost_d;
            stall      <= stall_d;
        end
    end

endmodule
